// File: rtl/mem_stage.sv
// Memory stage: EX/MEM pipeline register, branch resolution, ready-handshaked data-memory access
// with upstream stall, and the MEM/WB register feeding write-back and forwarding.
module mem_stage #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_alu_result,
  input  logic [31:0]            ex_write_data,
  input  logic [4:0]             ex_write_reg,
  input  logic                   ex_zero,
  input  logic [31:0]            ex_branch_target,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic                   ex_mem_to_reg,
  input  logic                   ex_branch,
  output logic                   mem_stall,
  output logic                   pc_src,
  output logic [31:0]            branch_target,
  output logic [31:0]            ex_mem_alu_result,
  output logic [4:0]             ex_mem_write_reg,
  output logic                   ex_mem_reg_write,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ready,
  input  logic [31:0]            dmem_rdata,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic [4:0]             wb_write_reg,
  output logic [31:0]            mem_wb_write_data,
  output logic                   err_misaligned,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic        exm_valid, exm_zero, exm_reg_write, exm_mem_read;
  logic        exm_mem_write, exm_mem_to_reg, exm_branch;
  logic [31:0] exm_alu_result, exm_write_data, exm_branch_target;
  logic [4:0]  exm_write_reg;

  logic mem_op, misaligned, aligned_op;

  assign mem_op     = exm_valid & (exm_mem_read | exm_mem_write);
  assign misaligned = mem_op & (exm_alu_result[1:0] != 2'b00);
  assign aligned_op = mem_op & ~misaligned;

  // Request is driven straight from EX/MEM, so reset clearing exm_valid drops it at once.
  assign mem_stall  = aligned_op & ~dmem_ready;
  assign dmem_req   = aligned_op;
  assign dmem_we    = aligned_op & exm_mem_write;
  assign dmem_addr  = exm_alu_result;
  assign dmem_wdata = exm_write_data;

  assign pc_src            = exm_valid & exm_branch & exm_zero;
  assign branch_target     = exm_branch_target;
  assign ex_mem_alu_result = exm_alu_result;
  assign ex_mem_write_reg  = exm_write_reg;
  assign ex_mem_reg_write  = exm_valid & exm_reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid         <= 1'b0;
      exm_alu_result    <= '0;
      exm_write_data    <= '0;
      exm_write_reg     <= '0;
      exm_zero          <= 1'b0;
      exm_branch_target <= '0;
      exm_reg_write     <= 1'b0;
      exm_mem_read      <= 1'b0;
      exm_mem_write     <= 1'b0;
      exm_mem_to_reg    <= 1'b0;
      exm_branch        <= 1'b0;
    end else if (!mem_stall) begin
      exm_valid         <= ex_valid;
      exm_alu_result    <= ex_alu_result;
      exm_write_data    <= ex_write_data;
      exm_write_reg     <= ex_write_reg;
      exm_zero          <= ex_zero;
      exm_branch_target <= ex_branch_target;
      exm_reg_write     <= ex_reg_write;
      exm_mem_read      <= ex_mem_read;
      exm_mem_write     <= ex_mem_write;
      exm_mem_to_reg    <= ex_mem_to_reg;
      exm_branch        <= ex_branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (aligned_op && !dmem_ready) state_q <= StWait;
        StWait:  if (dmem_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stalled cycles retire a bubble; misaligned ops retire as bubbles and stores never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid          <= 1'b0;
      wb_reg_write      <= 1'b0;
      wb_write_reg      <= '0;
      mem_wb_write_data <= '0;
    end else if (mem_stall) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid          <= exm_valid & ~misaligned;
      wb_reg_write      <= exm_valid & exm_reg_write & ~misaligned & ~exm_mem_write;
      wb_write_reg      <= exm_write_reg;
      mem_wb_write_data <= (exm_mem_read && exm_mem_to_reg) ? dmem_rdata : exm_alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misaligned <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      if (misaligned) err_misaligned <= 1'b1;
      if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-instruction behaviour plus hand-written
// sequences for wait states, back-to-back loads and reset during an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_branch;
  logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
  logic [4:0]  ex_write_reg;
  logic        mem_stall, pc_src, ex_mem_reg_write, dmem_req, dmem_we, dmem_ready;
  logic [31:0] branch_target, ex_mem_alu_result, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  ex_mem_write_reg, wb_write_reg;
  logic        wb_valid, wb_reg_write, err_misaligned;
  logic [31:0] mem_wb_write_data;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_write_reg(ex_write_reg), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_write_reg(ex_mem_write_reg),
    .ex_mem_reg_write(ex_mem_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .mem_wb_write_data(mem_wb_write_data), .err_misaligned(err_misaligned),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] btgt;
    logic [4:0]  rd;
    logic        zero, rw, mr, mw, m2r, br;
    logic [31:0] rdata;
    logic        e_req, e_we, e_pc, e_exmrw, e_wbv, e_wbrw, e_chk_data, e_err;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic m2r);
    ex_valid = v; ex_alu_result = alu; ex_write_data = wd; ex_write_reg = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
    ex_zero = 1'b0; ex_branch = 1'b0; ex_branch_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  int   req_cnt, stall_cnt, bubble_cnt;

  initial begin
    //         v  alu           wdata         btgt          rd  z  rw mr mw m2r br rdata
    //         req we pc exmrw wbv wbrw chk err data
    vecs[0] = '{1, 32'h10,       32'h0,        32'h0,        5,  0, 1, 0, 0, 0, 0, 32'h0,
                0, 0, 0, 1, 1, 1, 1, 0, 32'h10};
    vecs[1] = '{1, 32'h100,      32'h0,        32'h0,        7,  0, 1, 1, 0, 1, 0, 32'hCAFEF00D,
                1, 0, 0, 1, 1, 1, 1, 0, 32'hCAFEF00D};
    vecs[2] = '{1, 32'h204,      32'h12345678, 32'h0,        3,  0, 0, 0, 1, 0, 0, 32'h0,
                1, 1, 0, 0, 1, 0, 0, 0, 32'h0};
    vecs[3] = '{1, 32'h0,        32'h0,        32'h40,       0,  1, 0, 0, 0, 0, 1, 32'h0,
                0, 0, 1, 0, 1, 0, 0, 0, 32'h0};
    vecs[4] = '{1, 32'h8,        32'h0,        32'h40,       0,  0, 0, 0, 0, 0, 1, 32'h0,
                0, 0, 0, 0, 1, 0, 0, 0, 32'h0};
    vecs[5] = '{1, 32'h103,      32'h0,        32'h0,        9,  0, 1, 1, 0, 1, 0, 32'h55555555,
                0, 0, 0, 1, 0, 0, 0, 1, 32'h0};
    vecs[6] = '{0, 32'h77,       32'h0,        32'h0,        4,  0, 1, 0, 0, 0, 0, 32'h0,
                0, 0, 0, 0, 0, 0, 0, 1, 32'h0};
    vecs[7] = '{1, 32'h308,      32'h0,        32'h0,        12, 0, 1, 1, 0, 0, 0, 32'h99999999,
                1, 0, 0, 1, 1, 1, 1, 1, 32'h308};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_ready = 1'b0;
    dmem_rdata = '0;

    // Reset state
    #2;
    chk("rst_mem_stall", {31'b0, mem_stall}, 0);
    chk("rst_pc_src", {31'b0, pc_src}, 0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_wb_reg_write", {31'b0, wb_reg_write}, 0);
    chk("rst_wb_data", mem_wb_write_data, 0);
    chk("rst_exm_alu", ex_mem_alu_result, 0);
    chk("rst_err", {31'b0, err_misaligned}, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    do_reset();

    // Single-instruction vectors, zero-wait memory
    foreach (vecs[i]) begin
      ex_valid = vecs[i].valid; ex_alu_result = vecs[i].alu; ex_write_data = vecs[i].wdata;
      ex_branch_target = vecs[i].btgt; ex_write_reg = vecs[i].rd; ex_zero = vecs[i].zero;
      ex_reg_write = vecs[i].rw; ex_mem_read = vecs[i].mr; ex_mem_write = vecs[i].mw;
      ex_mem_to_reg = vecs[i].m2r; ex_branch = vecs[i].br;
      dmem_ready = 1'b1; dmem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d_dmem_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_mem_stall", i), {31'b0, mem_stall}, 0);
      chk($sformatf("v%0d_pc_src", i), {31'b0, pc_src}, {31'b0, vecs[i].e_pc});
      chk($sformatf("v%0d_exm_reg_write", i), {31'b0, ex_mem_reg_write},
          {31'b0, vecs[i].e_exmrw});
      chk($sformatf("v%0d_exm_alu", i), ex_mem_alu_result, vecs[i].alu);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_dmem_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
        chk($sformatf("v%0d_dmem_addr", i), dmem_addr, vecs[i].alu);
        if (vecs[i].e_we) chk($sformatf("v%0d_dmem_wdata", i), dmem_wdata, vecs[i].wdata);
      end
      if (vecs[i].e_pc) chk($sformatf("v%0d_branch_target", i), branch_target, vecs[i].btgt);
      ex_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_wbv});
      chk($sformatf("v%0d_wb_reg_write", i), {31'b0, wb_reg_write}, {31'b0, vecs[i].e_wbrw});
      chk($sformatf("v%0d_pc_src_clear", i), {31'b0, pc_src}, 0);
      chk($sformatf("v%0d_err", i), {31'b0, err_misaligned}, {31'b0, vecs[i].e_err});
      if (vecs[i].e_wbv) chk($sformatf("v%0d_wb_write_reg", i), {27'b0, wb_write_reg},
                             {27'b0, vecs[i].rd});
      if (vecs[i].e_chk_data) chk($sformatf("v%0d_wb_data", i), mem_wb_write_data,
                                  vecs[i].e_data);
    end
    chk("zero_wait_stall_cycles", stall_cycles, 0);

    // Load with three wait states
    do_reset();
    drive(1, 32'h100, 32'h0, 5'd6, 1, 1, 0, 1);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    req_cnt = 0; stall_cnt = 0; bubble_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
      end
      #1;
      if (dmem_req) req_cnt++;
      if (mem_stall) stall_cnt++;
      if (c >= 1 && !wb_valid && !wb_reg_write) bubble_cnt++;
      chk($sformatf("wait_addr_c%0d", c), dmem_addr, 32'h100);
      chk($sformatf("wait_we_c%0d", c), {31'b0, dmem_we}, 0);
      @(posedge clk); #1;
    end
    chk("wait_req_cycles", req_cnt, 4);
    chk("wait_stall_cycles_seen", stall_cnt, 3);
    chk("wait_wb_bubbles", bubble_cnt, 3);
    chk("wait_wb_valid", {31'b0, wb_valid}, 1);
    chk("wait_wb_reg_write", {31'b0, wb_reg_write}, 1);
    chk("wait_wb_data", mem_wb_write_data, 32'hDEADBEEF);
    chk("wait_wb_write_reg", {27'b0, wb_write_reg}, 6);
    chk("wait_stall_counter", stall_cycles, 3);
    chk("wait_req_done", {31'b0, dmem_req}, 0);

    // Back-to-back zero-wait loads retire one per cycle
    dmem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dmem_rdata = 32'hA0000000 + k - 1;
      if (k < 3) drive(1, 32'h300 + 4 * k, 32'h0, 5'(10 + k), 1, 1, 0, 1);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("b2b_no_stall_k%0d", k), {31'b0, mem_stall}, 0);
      @(posedge clk); #1;
      if (k >= 1) begin
        chk($sformatf("b2b_wb_data_k%0d", k), mem_wb_write_data, 32'hA0000000 + k - 1);
        chk($sformatf("b2b_wb_reg_k%0d", k), {27'b0, wb_write_reg}, 32'(10 + k - 1));
        chk($sformatf("b2b_wb_valid_k%0d", k), {31'b0, wb_valid}, 1);
      end
    end
    chk("b2b_stall_counter", stall_cycles, 3);

    // Reset during WAIT abandons the access
    drive(1, 32'h400, 32'h0, 5'd8, 1, 1, 0, 1);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rw_stall_before", {31'b0, mem_stall}, 1);
    chk("rw_req_before", {31'b0, dmem_req}, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_req_drop", {31'b0, dmem_req}, 0);
    chk("rw_stall_drop", {31'b0, mem_stall}, 0);
    chk("rw_stall_cycles_rst", stall_cycles, 0);
    chk("rw_exm_reg_write_rst", {31'b0, ex_mem_reg_write}, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
    @(posedge clk); #1;
    chk("rw_no_wb_write", {31'b0, wb_reg_write}, 0);
    chk("rw_no_wb_valid", {31'b0, wb_valid}, 0);
    chk("rw_wb_data_rst", mem_wb_write_data, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rw_after_req", {31'b0, dmem_req}, 0);
    chk("rw_after_wb_write", {31'b0, wb_reg_write}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
